// File: rtl/axis_lfsr_src_if.sv
// AXI-stream bundle: tdata/tvalid/tlast flow from the source, tready flows back.
interface axis_if #(
  parameter int DATAW = 64
);
  logic [DATAW-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport out (output tdata, output tvalid, output tlast, input tready);
  modport in  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_lfsr_src.sv
// AXI-stream pseudo-random packet source driven by a 64-bit Galois LFSR,
// with selectable flow control, inter-packet gaps, packet limit and drop count.
module axis_lfsr_src_cfg_chk #(
  parameter logic [63:0] SEED = 64'hACE1ACE1ACE1ACE1,
  parameter int          N    = 16
);
  // An all-zero seed would lock the LFSR at zero forever.
  if (SEED == 64'd0) begin : g_bad_seed
    $error("axis_lfsr_src: SEED must be nonzero");
  end
  if (N < 1) begin : g_bad_n
    $error("axis_lfsr_src: N must be at least 1");
  end
endmodule

module axis_lfsr_src #(
  parameter int          N     = 16,
  parameter int          DATAW = 64,
  parameter logic [63:0] SEED  = 64'hACE1ACE1ACE1ACE1,
  parameter int          GAP   = 4,
  parameter int          CNTW  = 32
) (
  input  logic            clk,
  input  logic            s_rst,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [CNTW-1:0] pkt_limit,
  axis_if.out             m,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] pkt_cnt,
  output logic [15:0]     drops
);

  localparam int             BW        = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(N - 1);
  localparam int             GW        = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0]  GAP_LOAD  = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [63:0]    POLY      = 64'hD800000000000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  axis_lfsr_src_cfg_chk #(.SEED(SEED), .N(N)) u_cfg_chk ();

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  state_e          state_q, state_d;
  logic [63:0]     lfsr_q, lfsr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [1:0]      mode_q, mode_d;
  logic [CNTW-1:0] limit_q, limit_d;
  logic [CNTW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0]     drops_q, drops_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic            xfer;
  logic [CNTW-1:0] pkt_next;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    mode_d    = mode_q;
    limit_d   = limit_q;
    pkt_cnt_d = pkt_cnt_q;
    drops_d   = drops_q;
    done_d    = done_q;
    xfer      = (state_q == ST_RUN) && ((mode_q == 2'd1) || m.tready);
    pkt_next  = pkt_cnt_q + CNTW'(1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_d    = (mode == 2'd3) ? 2'd0 : mode;
          limit_d   = pkt_limit;
          lfsr_d    = SEED;
          beat_d    = {BW{1'b0}};
          pkt_cnt_d = {CNTW{1'b0}};
          drops_d   = 16'd0;
          done_d    = 1'b0;
          state_d   = ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          lfsr_d = lfsr_step(lfsr_q);
          // Mode 1 issues beats regardless of tready; count the ones nobody took.
          if ((mode_q == 2'd1) && !m.tready && (drops_q != 16'hFFFF)) begin
            drops_d = drops_q + 16'd1;
          end else begin
            drops_d = drops_q;
          end
          if (beat_q == LAST_BEAT) begin
            beat_d    = {BW{1'b0}};
            pkt_cnt_d = pkt_next;
            if ((limit_q != {CNTW{1'b0}}) && (pkt_next == limit_q)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else if ((mode_q == 2'd2) && (GAP > 0)) begin
              state_d = ST_GAP;
              gap_d   = GAP_LOAD;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_GAP: begin
        if (gap_q == {GW{1'b0}}) begin
          state_d = ST_RUN;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tvalid_d = (state_d == ST_RUN);
    tlast_d  = (state_d == ST_RUN) && (beat_d == LAST_BEAT);
    busy_d   = (state_d == ST_RUN) || (state_d == ST_GAP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= SEED;
      beat_q    <= {BW{1'b0}};
      gap_q     <= {GW{1'b0}};
      mode_q    <= 2'd0;
      limit_q   <= {CNTW{1'b0}};
      pkt_cnt_q <= {CNTW{1'b0}};
      drops_q   <= 16'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      mode_q    <= mode_d;
      limit_q   <= limit_d;
      pkt_cnt_q <= pkt_cnt_d;
      drops_q   <= drops_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
    end
  end

  assign m.tdata  = lfsr_q[DATAW-1:0];
  assign m.tvalid = tvalid_q;
  assign m.tlast  = tlast_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drops    = drops_q;

endmodule

// File: tb/tb_axis_lfsr_src.sv
// Directed bench for axis_lfsr_src with SEED = 1, N = 4, GAP = 4.
module tb_axis_lfsr_src;

  logic        clk = 1'b0;
  logic        s_rst;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] pkt_limit;
  logic        busy;
  logic        done;
  logic [31:0] pkt_cnt;
  logic [15:0] drops;
  int          n_cmp = 0;
  int          n_fail = 0;

  axis_if #(.DATAW(64)) m_if ();

  axis_lfsr_src #(
    .N(4), .DATAW(64), .SEED(64'h1), .GAP(4), .CNTW(32)
  ) dut (
    .clk(clk), .s_rst(s_rst), .start(start), .mode(mode), .pkt_limit(pkt_limit),
    .m(m_if), .busy(busy), .done(done), .pkt_cnt(pkt_cnt), .drops(drops)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // With seed 1 the first step injects D8.. and the next 59 steps are plain shifts.
  function automatic logic [63:0] exp_beat(input int k);
    logic [63:0] base;
    base = 64'hD800000000000000;
    if (k == 0) return 64'h1;
    return base >> (k - 1);
  endfunction

  initial begin
    int k;
    int cyc;
    logic seen;

    s_rst = 1'b1; start = 1'b0; mode = 2'd0; pkt_limit = 32'd0; m_if.tready = 1'b0;
    tick(); tick();
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tlast", m_if.tlast, 0);
    chk("rst_tdata", m_if.tdata, 64'h1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_drops", drops, 0);

    s_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (m_if.tvalid) seen = 1'b1;
    end
    chk("idle_no_valid", seen, 0);

    // start together with reset: reset wins
    s_rst = 1'b1; start = 1'b1;
    tick();
    s_rst = 1'b0; start = 1'b0;
    chk("rst_start_tvalid", m_if.tvalid, 0);
    chk("rst_start_busy", busy, 0);
    tick();
    chk("rst_start_tvalid2", m_if.tvalid, 0);

    // basic sequence, mode 0, limit 1
    mode = 2'd0; pkt_limit = 32'd1; m_if.tready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("basic_tvalid", m_if.tvalid, 1);
      chk("basic_tdata", m_if.tdata, exp_beat(i));
      chk("basic_tlast", m_if.tlast, (i == 3) ? 1 : 0);
      chk("basic_busy", busy, 1);
      tick();
    end
    chk("basic_done", done, 1);
    chk("basic_pkt_cnt", pkt_cnt, 1);
    chk("basic_tvalid_off", m_if.tvalid, 0);
    chk("basic_busy_off", busy, 0);
    chk("basic_lfsr_hold", m_if.tdata, 64'h1B00000000000000);

    // backpressure, mode 0, limit 2, random tready
    mode = 2'd0; pkt_limit = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0; cyc = 0;
    while (k < 8 && cyc < 200) begin
      chk("bp_tvalid", m_if.tvalid, 1);
      chk("bp_tdata", m_if.tdata, exp_beat(k));
      chk("bp_tlast", m_if.tlast, (k % 4 == 3) ? 1 : 0);
      m_if.tready = 1'($urandom_range(0, 1));
      tick();
      if (m_if.tready) k++;
      cyc++;
    end
    chk("bp_beats", k, 8);
    chk("bp_done", done, 1);
    chk("bp_pkt_cnt", pkt_cnt, 2);
    chk("bp_tvalid_off", m_if.tvalid, 0);

    // free-running, mode 1, limit 3, tready low for 5 cycles
    mode = 2'd1; pkt_limit = 32'd3; m_if.tready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("fr_tvalid", m_if.tvalid, 1);
      chk("fr_tdata", m_if.tdata, exp_beat(i));
      chk("fr_tlast", m_if.tlast, (i % 4 == 3) ? 1 : 0);
      m_if.tready = (i >= 2 && i <= 6) ? 1'b0 : 1'b1;
      tick();
    end
    chk("fr_done", done, 1);
    chk("fr_drops", drops, 5);
    chk("fr_pkt_cnt", pkt_cnt, 3);
    chk("fr_tvalid_off", m_if.tvalid, 0);

    // gaps, mode 2, unlimited, with an ignored start mid-run
    mode = 2'd2; pkt_limit = 32'd0; m_if.tready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 11; p++) begin
      for (int i = 0; i < 4; i++) begin
        chk("gap_tvalid", m_if.tvalid, 1);
        chk("gap_tdata", m_if.tdata, exp_beat(4 * p + i));
        chk("gap_tlast", m_if.tlast, (i == 3) ? 1 : 0);
        start = (p == 5 && i == 1) ? 1'b1 : 1'b0;
        tick();
      end
      start = 1'b0;
      for (int g = 0; g < 4; g++) begin
        chk("gap_idle_tvalid", m_if.tvalid, 0);
        chk("gap_idle_busy", busy, 1);
        if (g == 0) chk("gap_pkt_cnt", pkt_cnt, 64'(p + 1));
        tick();
      end
    end
    chk("gap_resume_tvalid", m_if.tvalid, 1);
    chk("gap_resume_tdata", m_if.tdata, exp_beat(44));
    chk("gap_total_pkts", pkt_cnt, 11);
    chk("gap_not_done", done, 0);

    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    chk("gap_rst_tvalid", m_if.tvalid, 0);
    chk("gap_rst_pkt_cnt", pkt_cnt, 0);

    // reset on beat 2 of packet 1 in mode 1 with drops pending
    mode = 2'd1; pkt_limit = 32'd0; m_if.tready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("mr_tdata", m_if.tdata, exp_beat(i));
      tick();
    end
    chk("mr_pre_tdata", m_if.tdata, exp_beat(6));
    chk("mr_pre_drops", drops, 6);
    chk("mr_pre_pkt_cnt", pkt_cnt, 1);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    chk("mr_tvalid", m_if.tvalid, 0);
    chk("mr_tlast", m_if.tlast, 0);
    chk("mr_tdata_seed", m_if.tdata, 64'h1);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_pkt_cnt", pkt_cnt, 0);
    chk("mr_drops", drops, 0);
    tick();
    chk("mr_stays_idle", m_if.tvalid, 0);

    // restart replays from seed
    mode = 2'd0; pkt_limit = 32'd1; m_if.tready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs_pkt_cnt0", pkt_cnt, 0);
    chk("rs_drops0", drops, 0);
    for (int i = 0; i < 4; i++) begin
      chk("rs_tvalid", m_if.tvalid, 1);
      chk("rs_tdata", m_if.tdata, exp_beat(i));
      chk("rs_tlast", m_if.tlast, (i == 3) ? 1 : 0);
      tick();
    end
    chk("rs_done", done, 1);
    chk("rs_pkt_cnt", pkt_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_lfsr_src.md
# axis_lfsr_src

Parametrised AXI-stream pseudo-random stimulus source for the multiplier synthesis harness. It replaces the fixed back-to-back generator on the `p` and `u` inputs of `multiplier_top`. It adds runtime-selectable flow-control modes, inter-packet gaps, a packet-count limit with done indication, and a drop counter. Each instance drives one stream of `N`-beat packets from a 64-bit Galois LFSR that reloads its seed on every start.

## Interface
Parameters:
- `N`, 16: beats per packet (tlast on beat `N-1`); must be ≥ 1.
- `DATAW`, 64: tdata width, 1..64; tdata = LFSR state bits `[DATAW-1:0]`.
- `SEED`, 64'hACE1ACE1ACE1ACE1: LFSR load value; must be nonzero (elaboration-time assertion).
- `GAP`, 4: idle cycles between packets in mode 2; 0 = no gap.
- `CNTW`, 32: width of `pkt_cnt` and `pkt_limit`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `s_rst`  in  1  synchronous reset, active-high.
- `start`  in  1  single-cycle pulse; begins a run from IDLE or DONE.
- `mode`  in  2  0 = honour tready; 1 = free-running, ignore tready; 2 = honour tready plus GAP; 3 = treated as 0. Sampled on accepted `start`.
- `pkt_limit`  in  CNTW  packets per run, 0 = unlimited. Sampled on accepted `start`.
- `m`  axis_if.out  DATAW  output stream (tdata, tvalid, tready, tlast).
- `busy`  out  1  high in RUN and GAP.
- `done`  out  1  high in DONE until next start or reset.
- `pkt_cnt`  out  CNTW  completed packets this run; wraps modulo 2^CNTW.
- `drops`  out  16  mode-1 beats issued while tready = 0; saturates at 16'hFFFF.

## Operation
- **LFSR step:** `s = s[0] ? (s >> 1) ^ 64'hD800000000000000 : s >> 1`. This is the maximal polynomial x^64+x^63+x^61+x^60+1.
- **FSM states:** IDLE, RUN, GAP, DONE.
- **IDLE/DONE + start:**
  - Latch `mode` and `pkt_limit`.
  - Load LFSR = SEED; clear beat counter, `pkt_cnt`, `drops` and `done`.
  - Go to RUN.
- **start in RUN/GAP:** ignored.
- **RUN:**
  - tvalid = 1.
  - A beat is transferred when tvalid && tready (modes 0, 2), or on every RUN cycle (mode 1).
  - On transfer, the LFSR steps and the beat counter increments.
  - tlast = (beat == N-1).
  - In mode 1, a transfer with tready = 0 increments `drops`.
- **End of packet (transfer with tlast):**
  - `pkt_cnt` increments and the beat counter clears.
  - If `pkt_limit` ≠ 0 and the new `pkt_cnt` == `pkt_limit`, go to DONE.
  - Else if mode 2 and GAP > 0, go to GAP.
  - Else stay in RUN; the next packet starts the following cycle.
- **GAP:** tvalid = 0 for exactly GAP cycles, then RUN.
- **DONE:** tvalid = 0, `done` = 1, `busy` = 0. The LFSR holds.
- **Stall (modes 0/2):** tdata, tlast and tvalid stay stable while tready = 0. tvalid never drops mid-packet.
- **N = 1:** every beat has tlast = 1.
- **Reset mid-operation:** state returns to IDLE on the next edge, regardless of handshake state. The in-flight packet is abandoned; there is no partial-packet completion.

## Timing
- **Reset values:**
  - state IDLE; LFSR = SEED.
  - tvalid = 0, tlast = 0, tdata = SEED[DATAW-1:0].
  - busy = 0, done = 0, pkt_cnt = 0, drops = 0.
  - Latched mode = 0, latched limit = 0.
- **Start latency:** `start` at edge k gives tvalid = 1 and tdata = SEED[DATAW-1:0] after edge k+1 (one cycle).
- **Throughput:** one beat per cycle when tready = 1 (or always, in mode 1).
- **Packet boundary:** the cycle after the tlast transfer shows the first beat of the next packet (no gap) or tvalid = 0 (GAP/DONE).
- **`pkt_cnt`:** updates on the same edge as the tlast transfer.
- **`done`:** rises one cycle after the final tlast transfer.
- **Simultaneous `start` and `s_rst`:** reset wins.
- **Outputs:** all registered or derived only from registers; no combinational path from tready to tvalid or tdata.

## Test plan
- **Reset values:** assert `s_rst` → all outputs at reset values. Release, no start → tvalid stays 0 for 100 cycles.
- **Basic sequence and start latency:** SEED = 1, DATAW = 64, N = 4, mode 0, limit 1, tready = 1, start →
  - tdata = 0x1, 0xD800000000000000, 0x6C00000000000000, 0x3600000000000000 on consecutive cycles.
  - tlast on the 4th beat.
  - `done` = 1 and `pkt_cnt` = 1 one cycle later.
- **Backpressure:** mode 0, random tready (50%) → tdata/tlast stable on every stalled cycle. Beat stream identical to the no-stall run.
- **Free-running drops:** mode 1, limit 3, tready low for 5 cycles → 12 beats in 12 consecutive cycles, `drops` = 5, `done` after 3 packets.
- **Gaps and unlimited run:** mode 2, GAP = 4, limit 0 →
  - exactly 4 tvalid = 0 cycles between every tlast and the next beat.
  - runs past 10 packets with `pkt_cnt` incrementing.
  - `start` mid-run ignored.
- **Reset and restart:** reset asserted on beat 2 of packet 1 → IDLE next edge. Restart replays from SEED with `pkt_cnt` = 0 and `drops` = 0.
